// File: rtl/job_engine_pkg.sv
// Shared widths and FSM state encoding for the job engine.
package job_engine_pkg;

    localparam int unsigned JOB_DATA_W  = 8;
    localparam int unsigned JOB_LEN_W   = 8;
    localparam int unsigned JOB_TIMEOUT = 16;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        XFER   = 2'd1,
        FINISH = 2'd2,
        FAIL   = 2'd3
    } job_state_t;

endpackage

// File: rtl/job_stall_timer.sv
// Saturating stall counter; expired flags TIMEOUT-1 consecutive ticks since clear.
module job_stall_timer
    import job_engine_pkg::*;
#(
    parameter int unsigned TIMEOUT = JOB_TIMEOUT
) (
    input  logic clk,
    input  logic reset,
    input  logic clear,
    input  logic tick,
    output logic expired
);

    localparam int unsigned CNT_W = $clog2(TIMEOUT);
    localparam logic [CNT_W-1:0] LAST = CNT_W'(TIMEOUT - 1);

    logic [CNT_W-1:0] r_count;

    // Holds at LAST instead of wrapping so a long stall can never look fresh.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_count <= '0;
        end else if (clear) begin
            r_count <= '0;
        end else if (tick && (r_count != LAST)) begin
            r_count <= r_count + CNT_W'(1);
        end
    end

    assign expired = (r_count == LAST);

endmodule

// File: rtl/job_engine.sv
// Runs one stream-consuming job per start request and reports done or error.
module job_engine
    import job_engine_pkg::*;
#(
    parameter int unsigned DATA_W  = JOB_DATA_W,
    parameter int unsigned LEN_W   = JOB_LEN_W,
    parameter int unsigned TIMEOUT = JOB_TIMEOUT
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic [LEN_W-1:0]  job_len,
    input  logic              in_valid,
    input  logic [DATA_W-1:0] in_data,
    output logic              in_ready,
    output logic              done,
    output logic              error,
    output logic [DATA_W-1:0] checksum,
    output logic [LEN_W-1:0]  beat_count
);

    job_state_t        r_state;
    logic              r_in_ready;
    logic              r_done;
    logic              r_error;
    logic [DATA_W-1:0] r_checksum;
    logic [LEN_W-1:0]  r_beat_count;
    logic [LEN_W-1:0]  r_remaining;

    logic w_accept;
    logic w_in_xfer;
    logic w_stall_clear;
    logic w_stall_tick;
    logic w_expired;

    assign w_in_xfer     = (r_state == XFER);
    assign w_accept      = in_valid && r_in_ready;
    assign w_stall_clear = !w_in_xfer || w_accept;
    assign w_stall_tick  = w_in_xfer && !w_accept;

    job_stall_timer #(
        .TIMEOUT (TIMEOUT)
    ) u_stall_timer (
        .clk     (clk),
        .reset   (reset),
        .clear   (w_stall_clear),
        .tick    (w_stall_tick),
        .expired (w_expired)
    );

    // Control FSM; pulses and in_ready are registered alongside the state.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state      <= IDLE;
            r_in_ready   <= 1'b0;
            r_done       <= 1'b0;
            r_error      <= 1'b0;
            r_checksum   <= '0;
            r_beat_count <= '0;
            r_remaining  <= '0;
        end else begin
            r_done  <= 1'b0;
            r_error <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (start) begin
                        if (job_len != '0) begin
                            r_remaining  <= job_len;
                            r_checksum   <= '0;
                            r_beat_count <= '0;
                            r_in_ready   <= 1'b1;
                            r_state      <= XFER;
                        end else begin
                            r_error <= 1'b1;
                            r_state <= FAIL;
                        end
                    end
                end
                XFER: begin
                    // An accepted beat wins over a timeout in the same cycle.
                    if (w_accept) begin
                        r_checksum   <= r_checksum + in_data;
                        r_beat_count <= r_beat_count + LEN_W'(1);
                        r_remaining  <= r_remaining - LEN_W'(1);
                        if (r_remaining == LEN_W'(1)) begin
                            r_in_ready <= 1'b0;
                            r_done     <= 1'b1;
                            r_state    <= FINISH;
                        end
                    end else if (w_expired) begin
                        r_in_ready <= 1'b0;
                        r_error    <= 1'b1;
                        r_state    <= FAIL;
                    end
                end
                FINISH:  r_state <= IDLE;
                FAIL:    r_state <= IDLE;
                default: r_state <= IDLE;
            endcase
        end
    end

    assign in_ready   = r_in_ready;
    assign done       = r_done;
    assign error      = r_error;
    assign checksum   = r_checksum;
    assign beat_count = r_beat_count;

endmodule
